// File: rtl/vertex_transform.sv
// vertex_transform
//   Rotates the cube's model-space vertices about Y, then X, and projects them
//   orthographically to screen space.
//   Works one vertex at a time: 3 cycles per vertex.
//   Results collect in a back buffer. The front buffer is replaced in a single
//   edge, so the rasterizer never sees a partly updated vertex set.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_frame          one-cycle start strobe (vblank)
//   i_vertices_3d    model vertices, signed 10-bit x/y/z
//   i_sin_y/i_cos_y  Y-axis rotation, signed Q2.7 (128 = 1.0)
//   i_sin_x/i_cos_x  X-axis rotation, signed Q2.7
//   o_vertices_2d    front buffer: unsigned 10-bit x/y, signed 10-bit z
//   o_busy           transform in progress
//   o_done           one-cycle pulse when a new set is published
//   o_valid          sticky, set once any set has been published
//   o_overrun        one-cycle pulse after a frame strobe arrives while busy
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for frame; inputs are latched on frame
// ROT_Y   | rotate vertex[idx] about Y -> xr, zr
// ROT_X   | rotate about X -> yr, zf
// STORE   | project, clamp and write back[idx]
// SWAP    | copy back buffer to front, pulse done

package graphics_type;
    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic signed [9:0] z;
    } vertex_3d_t;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic signed [9:0] z;
    } vertex_2d_t;
endpackage

module vertex_transform
    import graphics_type::*;
#(
    parameter int NUM_VERTS = 8,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int CENTER_X  = 320,
    parameter int CENTER_Y  = 240
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame,
    input  vertex_3d_t        i_vertices_3d [0:NUM_VERTS-1],
    input  logic signed [8:0] i_sin_y,
    input  logic signed [8:0] i_cos_y,
    input  logic signed [8:0] i_sin_x,
    input  logic signed [8:0] i_cos_x,
    output vertex_2d_t        o_vertices_2d [0:NUM_VERTS-1],
    output logic              o_busy,
    output logic              o_done,
    output logic              o_valid,
    output logic              o_overrun
);

    localparam int IDX_W = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_VERTS - 1);
    localparam logic signed [14:0] SX_MAX   = 15'(SCREEN_W - 1);
    localparam logic signed [14:0] SY_MAX   = 15'(SCREEN_H - 1);
    localparam logic signed [16:0] Z_MAX    = 17'sd511;
    localparam logic signed [16:0] Z_MIN    = -17'sd512;

    typedef enum logic [2:0] {S_IDLE, S_ROT_Y, S_ROT_X, S_STORE, S_SWAP} state_t;

    state_t r_state, w_state_nxt;

    vertex_3d_t        r_v3d   [0:NUM_VERTS-1];
    vertex_2d_t        r_back  [0:NUM_VERTS-1];
    vertex_2d_t        r_front [0:NUM_VERTS-1];
    logic signed [8:0] r_sin_y, r_cos_y, r_sin_x, r_cos_x;
    logic [IDX_W-1:0]  r_idx;
    logic signed [12:0] r_xr, r_zr, r_yr;
    logic signed [16:0] r_zf;
    logic              r_done, r_valid, r_overrun;

    logic w_latch, w_busy, w_rot_y, w_rot_x, w_store, w_swap, w_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_frame) w_state_nxt = S_ROT_Y;
            S_ROT_Y: w_state_nxt = S_ROT_X;
            S_ROT_X: w_state_nxt = S_STORE;
            S_STORE: w_state_nxt = w_last ? S_SWAP : S_ROT_Y;
            S_SWAP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_latch = 1'b0;
        w_busy  = 1'b1;
        w_rot_y = 1'b0;
        w_rot_x = 1'b0;
        w_store = 1'b0;
        w_swap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_latch = i_frame;
            end
            S_ROT_Y: w_rot_y = 1'b1;
            S_ROT_X: w_rot_x = 1'b1;
            S_STORE: w_store = 1'b1;
            S_SWAP:  w_swap  = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    assign w_last = (r_idx == IDX_LAST);

    // ---------------- arithmetic ----------------
    vertex_3d_t         w_cur;
    logic signed [19:0] w_sum_xr, w_sum_zr;
    logic signed [23:0] w_sum_yr, w_sum_zf;
    logic signed [12:0] w_xr, w_zr, w_yr;
    logic signed [16:0] w_zf;
    logic signed [14:0] w_sx_full, w_sy_full;
    vertex_2d_t         w_proj;

    assign w_cur = r_v3d[r_idx];

    assign w_sum_xr = 20'(w_cur.x) * 20'(r_cos_y) + 20'(w_cur.z) * 20'(r_sin_y);
    assign w_sum_zr = 20'(w_cur.z) * 20'(r_cos_y) - 20'(w_cur.x) * 20'(r_sin_y);
    assign w_xr     = 13'(w_sum_xr >>> 7);
    assign w_zr     = 13'(w_sum_zr >>> 7);

    // zr is 13 bits here, so the X-rotation sums need more headroom than Y's
    assign w_sum_yr = 24'(w_cur.y) * 24'(r_cos_x) - 24'(r_zr) * 24'(r_sin_x);
    assign w_sum_zf = 24'(w_cur.y) * 24'(r_sin_x) + 24'(r_zr) * 24'(r_cos_x);
    assign w_yr     = 13'(w_sum_yr >>> 7);
    assign w_zf     = 17'(w_sum_zf >>> 7);

    assign w_sx_full = 15'(CENTER_X) + 15'(r_xr);
    assign w_sy_full = 15'(CENTER_Y) - 15'(r_yr);

    always_comb begin
        w_proj = '0;
        if (w_sx_full < 15'sd0)      w_proj.x = '0;
        else if (w_sx_full > SX_MAX) w_proj.x = SX_MAX[9:0];
        else                         w_proj.x = w_sx_full[9:0];

        if (w_sy_full < 15'sd0)      w_proj.y = '0;
        else if (w_sy_full > SY_MAX) w_proj.y = SY_MAX[9:0];
        else                         w_proj.y = w_sy_full[9:0];

        if (r_zf > Z_MAX)            w_proj.z = Z_MAX[9:0];
        else if (r_zf < Z_MIN)       w_proj.z = Z_MIN[9:0];
        else                         w_proj.z = r_zf[9:0];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_VERTS; i++) begin
                r_v3d[i]   <= '0;
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
            r_sin_y   <= '0;
            r_cos_y   <= '0;
            r_sin_x   <= '0;
            r_cos_x   <= '0;
            r_idx     <= '0;
            r_xr      <= '0;
            r_zr      <= '0;
            r_yr      <= '0;
            r_zf      <= '0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_latch) begin
                r_v3d   <= i_vertices_3d;
                r_sin_y <= i_sin_y;
                r_cos_y <= i_cos_y;
                r_sin_x <= i_sin_x;
                r_cos_x <= i_cos_x;
                r_idx   <= '0;
            end
            if (w_rot_y) begin
                r_xr <= w_xr;
                r_zr <= w_zr;
            end
            if (w_rot_x) begin
                r_yr <= w_yr;
                r_zf <= w_zf;
            end
            if (w_store) begin
                r_back[r_idx] <= w_proj;
                if (!w_last) r_idx <= r_idx + IDX_W'(1);
            end
            if (w_swap) r_front <= r_back;
            r_done    <= w_swap;
            r_valid   <= r_valid | w_swap;
            // SWAP counts as busy, so a strobe on the publishing edge is an overrun
            r_overrun <= i_frame & w_busy;
        end
    end

    assign o_vertices_2d = r_front;
    assign o_busy        = w_busy;
    assign o_done        = r_done;
    assign o_valid       = r_valid;
    assign o_overrun     = r_overrun;

endmodule
